// File: rtl/libconf.sv
// Build configuration: hardware thread count and thread-id width.
package libconf;

    localparam int NTHREAD      = 8;
    localparam int NTHREADIDMSB = 2;

endpackage

// File: rtl/libstd.sv
// Shared clock bundle type and small constant helpers.
package libstd;

    // Clock bundle distributed to the integer-unit timing blocks.
    typedef struct packed {
        logic clk;
    } iu_clk_type;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int log2x(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/libtm.sv
// Timing-model token types exchanged with the host CPU pipeline.
package libtm;
    import libconf::*;

    localparam int TM_PIPE_DEPTH_DEFLT = 7;

    // Issue token from the timing model.
    typedef struct packed {
        logic [NTHREADIDMSB:0] tid;
        logic                  valid;
        logic                  run;
        logic                  running;
    } tm2cpu_token_type;

    // Retire/replay report back to the timing model.
    typedef struct packed {
        logic                  valid;
        logic                  replay;
        logic [NTHREADIDMSB:0] tid;
    } tm_cpu_ctrl_token_type;

endpackage

// File: rtl/tm_cpu_retire_gen_pkg.sv
// Local types and helpers for the retire/replay generator.
package tm_cpu_retire_gen_pkg;
    import libconf::*;

    // One slot of the issue-to-report delay line.
    typedef struct packed {
        logic                  valid;
        logic [NTHREADIDMSB:0] tid;
    } stage_slot_t;

    localparam int SLOT_W = $bits(stage_slot_t);

    // True when a qualified event targets the given thread.
    function automatic logic tid_hit(input logic                  i_v,
                                     input logic [NTHREADIDMSB:0] i_a,
                                     input logic [NTHREADIDMSB:0] i_b);
        return i_v && (i_a == i_b);
    endfunction

endpackage

// File: rtl/tm_cpu_retire_gen_delay.sv
// Fixed-latency shift register; never stalls, reset empties all stages.
module tm_token_delay #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Advance every stage by one each clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/tm_cpu_retire_gen.sv
// Retire/replay generator: delays issued tokens by PIPE_DEPTH cycles and
// reports each one as retire or replay depending on memory nack and the
// per-thread miss-blocked state.
module tm_cpu_retire_gen
    import libstd::*;
    import libconf::*;
    import libtm::*;
    import tm_cpu_retire_gen_pkg::*;
#(
    parameter int PIPE_DEPTH = TM_PIPE_DEPTH_DEFLT,
    parameter int NTHR       = NTHREAD
) (
    input  iu_clk_type                          gclk,
    input  logic                                rst,
    input  tm2cpu_token_type                    tm2cpu,
    input  logic                                mem_nack,
    input  logic                                refill_valid,
    input  logic [NTHREADIDMSB:0]               refill_tid,
    output tm_cpu_ctrl_token_type               cpu2tm,
    output logic [log2x(PIPE_DEPTH+1)-1:0]      inflight_cnt,
    output logic                                dup_err
);

    localparam int CW = log2x(PIPE_DEPTH + 1);

    logic                  w_accept;
    stage_slot_t           w_issue;
    stage_slot_t           w_last;
    logic                  w_hold;
    logic                  w_report;
    logic                  w_self_rep;
    logic [NTHR-1:0]       w_blocked_nxt;
    logic [NTHR-1:0]       w_inflight_nxt;
    logic [CW-1:0]         w_cnt_nxt;

    tm_cpu_ctrl_token_type r_cpu2tm;
    logic [NTHR-1:0]       r_blocked;
    logic [NTHR-1:0]       r_inflight;
    logic [CW-1:0]         r_cnt;
    logic                  r_dup;

    assign w_accept      = tm2cpu.valid & tm2cpu.run & tm2cpu.running;
    assign w_issue.valid = w_accept;
    assign w_issue.tid   = tm2cpu.tid;

    // The registered cpu2tm output is the final stage, so the line is one shorter.
    tm_token_delay #(
        .DEPTH (PIPE_DEPTH - 1),
        .WIDTH (SLOT_W)
    ) u_delay (
        .i_clk  (gclk.clk),
        .i_rst  (rst),
        .i_data (w_issue),
        .o_data (w_last)
    );

    // A refill landing this cycle already unblocks the last-stage token.
    assign w_hold = mem_nack |
                    (r_blocked[w_last.tid] & ~tid_hit(refill_valid, refill_tid, w_last.tid));

    // The token sitting on cpu2tm this cycle is the one being reported.
    assign w_report   = r_cpu2tm.valid | r_cpu2tm.replay;
    assign w_self_rep = tid_hit(w_report, r_cpu2tm.tid, tm2cpu.tid);

    // Blocked vector: refill clears, nack on a real token sets; set wins.
    always_comb begin
        w_blocked_nxt = r_blocked;
        if (refill_valid) begin
            w_blocked_nxt[refill_tid] = 1'b0;
        end
        if (w_last.valid && mem_nack) begin
            w_blocked_nxt[w_last.tid] = 1'b1;
        end
    end

    // Inflight vector: report clears, accept sets; set wins for a same-tid handoff.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_report) begin
            w_inflight_nxt[r_cpu2tm.tid] = 1'b0;
        end
        if (w_accept) begin
            w_inflight_nxt[tm2cpu.tid] = 1'b1;
        end
    end

    // Occupancy: up on accept, down on report, flat when both.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && !w_report) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_accept && w_report) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    // State and registered report; reset drops everything in flight silently.
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            r_cpu2tm   <= '0;
            r_blocked  <= '0;
            r_inflight <= '0;
            r_cnt      <= '0;
            r_dup      <= 1'b0;
        end else begin
            r_cpu2tm.valid  <= w_last.valid & ~w_hold;
            r_cpu2tm.replay <= w_last.valid & w_hold;
            if (w_last.valid) begin
                r_cpu2tm.tid <= w_last.tid;
            end
            r_blocked  <= w_blocked_nxt;
            r_inflight <= w_inflight_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_accept && r_inflight[tm2cpu.tid] && !w_self_rep) begin
                r_dup <= 1'b1;
            end
        end
    end

    assign cpu2tm       = r_cpu2tm;
    assign inflight_cnt = r_cnt;
    assign dup_err      = r_dup;

endmodule

// File: tb/tb_tm_cpu_retire_gen.sv
// Bench for tm_cpu_retire_gen: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_tm_cpu_retire_gen;
    import libstd::*;
    import libconf::*;
    import libtm::*;

    localparam int P    = 7;
    localparam int CW   = log2x(P + 1);
    localparam int TIDW = NTHREADIDMSB + 1;

    logic                  clk = 1'b0;
    iu_clk_type            gclk;
    logic                  rst;
    tm2cpu_token_type      tm2cpu;
    logic                  mem_nack;
    logic                  refill_valid;
    logic [TIDW-1:0]       refill_tid;
    tm_cpu_ctrl_token_type cpu2tm;
    logic [CW-1:0]         inflight_cnt;
    logic                  dup_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    assign gclk = clk;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tm_cpu_retire_gen #(
        .PIPE_DEPTH (P),
        .NTHR       (NTHREAD)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .tm2cpu       (tm2cpu),
        .mem_nack     (mem_nack),
        .refill_valid (refill_valid),
        .refill_tid   (refill_tid),
        .cpu2tm       (cpu2tm),
        .inflight_cnt (inflight_cnt),
        .dup_err      (dup_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outstanding tokens with the cycle they must be reported.
    typedef struct {
        int tid;
        int due;
    } tok_t;

    tok_t q[$];
    bit   m_ready = 1'b0;
    bit   m_blk [NTHREAD];
    bit   m_dup = 1'b0;
    bit   m_v = 1'b0;
    bit   m_r = 1'b0;
    int   m_tid = 0;
    bit   m_has_last;
    bit   m_hold;
    int   m_last_tid;

    always @(negedge clk) begin
        if (m_ready) begin
            chk("cpu2tm_valid",  cpu2tm.valid,  m_v);
            chk("cpu2tm_replay", cpu2tm.replay, m_r);
            chk("cpu2tm_tid",    cpu2tm.tid,    m_tid);
            chk("inflight_cnt",  inflight_cnt,  q.size());
            chk("dup_err",       dup_err,       m_dup);
        end
        if (rst) begin
            q.delete();
            foreach (m_blk[i]) m_blk[i] = 1'b0;
            m_dup = 1'b0; m_v = 1'b0; m_r = 1'b0; m_tid = 0;
            m_ready = 1'b1;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            m_has_last = (q.size() > 0) && (q[0].due == cyc + 1);
            m_v = 1'b0;
            m_r = 1'b0;
            if (m_has_last) begin
                m_last_tid = q[0].tid;
                m_hold = mem_nack ||
                         (m_blk[m_last_tid] && !(refill_valid && int'(refill_tid) == m_last_tid));
                m_v   = !m_hold;
                m_r   = m_hold;
                m_tid = m_last_tid;
            end
            if (refill_valid) m_blk[refill_tid] = 1'b0;
            if (m_has_last && mem_nack) m_blk[m_last_tid] = 1'b1;
            if (tm2cpu.valid && tm2cpu.run && tm2cpu.running) begin
                foreach (q[i]) if (q[i].tid == int'(tm2cpu.tid)) m_dup = 1'b1;
                q.push_back('{tid: int'(tm2cpu.tid), due: cyc + P});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tm2cpu.valid = 1'b0;
        tm2cpu.tid   = '0;
        mem_nack     = 1'b0;
        refill_valid = 1'b0;
        refill_tid   = '0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input int t);
        tm2cpu.valid = 1'b1;
        tm2cpu.tid   = TIDW'(t);
    endtask

    initial begin
        rst = 1'b1;
        tm2cpu = '0;
        tm2cpu.run = 1'b1;
        tm2cpu.running = 1'b1;
        mem_nack = 1'b0;
        refill_valid = 1'b0;
        refill_tid = '0;

        run_to(5); rst = 1'b0;

        // basic retire, latency and occupancy
        run_to(10); issue(3);
        run_to(11); chk("s1_cnt_first", inflight_cnt, 1);
        run_to(16); chk("s1_not_early", cpu2tm.valid, 0);
        run_to(17);
        chk("s1_valid", cpu2tm.valid, 1);
        chk("s1_replay", cpu2tm.replay, 0);
        chk("s1_tid", cpu2tm.tid, 3);
        chk("s1_cnt_last", inflight_cnt, 1);
        run_to(18);
        chk("s1_cnt_drained", inflight_cnt, 0);
        chk("s1_idle_valid", cpu2tm.valid, 0);
        chk("s1_tid_hold", cpu2tm.tid, 3);

        // nack blocks, replay persists, early refill unblocks
        run_to(20); issue(5);
        run_to(26); mem_nack = 1'b1;
        run_to(27);
        chk("s2_replay", cpu2tm.replay, 1);
        chk("s2_valid", cpu2tm.valid, 0);
        chk("s2_tid", cpu2tm.tid, 5);
        run_to(28); issue(5);
        run_to(35); chk("s2_still_blocked", cpu2tm.replay, 1);
        run_to(36); issue(5);
        run_to(41); refill_valid = 1'b1; refill_tid = 3'd5;
        run_to(43);
        chk("s2_retire_valid", cpu2tm.valid, 1);
        chk("s2_retire_replay", cpu2tm.replay, 0);

        // same-cycle nack and refill: set wins; then same-cycle refill bypass
        run_to(50); issue(2);
        run_to(56); mem_nack = 1'b1; refill_valid = 1'b1; refill_tid = 3'd2;
        run_to(57);
        chk("s3_replay", cpu2tm.replay, 1);
        chk("s3_tid", cpu2tm.tid, 2);
        run_to(58); issue(2);
        run_to(65); chk("s3_blocked_kept", cpu2tm.replay, 1);
        run_to(66); issue(2);
        run_to(72); refill_valid = 1'b1; refill_tid = 3'd2;
        run_to(73);
        chk("s3_bypass_valid", cpu2tm.valid, 1);
        chk("s3_bypass_replay", cpu2tm.replay, 0);

        // duplicate issue
        run_to(80); rst = 1'b1;
        run_to(82); rst = 1'b0;
        run_to(83); issue(1);
        run_to(85); chk("s4_dup_before", dup_err, 0); issue(1);
        run_to(86); chk("s4_dup_set", dup_err, 1);

        // report and accept of the same tid in one cycle
        run_to(100); rst = 1'b1;
        run_to(102); rst = 1'b0; chk("s4b_dup_reset", dup_err, 0);
        run_to(103); issue(1);
        run_to(110);
        chk("s4b_report", cpu2tm.valid, 1);
        chk("s4b_report_tid", cpu2tm.tid, 1);
        issue(1);
        run_to(111); chk("s4b_no_dup", dup_err, 0);
        run_to(117); chk("s4b_second_report", cpu2tm.valid, 1);

        // running drops after the fourth issue
        for (int i = 0; i < 8; i++) begin
            run_to(120 + i);
            if (i == 4) begin
                tm2cpu.running = 1'b0;
                chk("s5_cnt_four", inflight_cnt, 4);
            end
            if (i == 7) begin
                chk("s5_first_valid", cpu2tm.valid, 1);
                chk("s5_first_tid", cpu2tm.tid, 0);
            end
            issue(i);
        end
        run_to(128); tm2cpu.running = 1'b1; chk("s5_second_tid", cpu2tm.tid, 1);
        run_to(130);
        chk("s5_last_valid", cpu2tm.valid, 1);
        chk("s5_last_tid", cpu2tm.tid, 3);
        run_to(131);
        chk("s5_no_fifth", cpu2tm.valid, 0);
        chk("s5_cnt_zero", inflight_cnt, 0);

        // reset with tokens in flight
        for (int i = 0; i < 5; i++) begin
            run_to(140 + i); issue(i);
        end
        run_to(146); chk("s6_cnt_five", inflight_cnt, 5); rst = 1'b1;
        run_to(147);
        chk("s6_rst_valid", cpu2tm.valid, 0);
        chk("s6_rst_replay", cpu2tm.replay, 0);
        chk("s6_rst_tid", cpu2tm.tid, 0);
        chk("s6_rst_cnt", inflight_cnt, 0);
        run_to(148); rst = 1'b0; issue(6);
        run_to(150); chk("s6_discarded", cpu2tm.valid, 0);
        run_to(155);
        chk("s6_post_valid", cpu2tm.valid, 1);
        chk("s6_post_tid", cpu2tm.tid, 6);
        run_to(156); chk("s6_post_cnt", inflight_cnt, 0);

        // mixed traffic against the model
        run_to(160); rst = 1'b1;
        run_to(162); rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 1) issue(int'($urandom_range(0, 7)));
            mem_nack       = ($urandom_range(0, 3) == 0);
            refill_valid   = ($urandom_range(0, 3) == 0);
            refill_tid     = TIDW'($urandom_range(0, 7));
            tm2cpu.running = ($urandom_range(0, 7) != 0);
            step();
        end
        tm2cpu.running = 1'b1;
        run_to(cyc + 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
